// File: rtl/sample_generator_pkg.sv
// Shared encodings and PRBS15 constants for the sample_generator capture source.
package sample_generator_pkg;

    typedef enum logic [1:0] {
        MODE_ADC   = 2'd0,
        MODE_RAMP  = 2'd1,
        MODE_PRBS  = 2'd2,
        MODE_CONST = 2'd3
    } mode_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PRIME = 2'd1,
        ST_RUN   = 2'd2
    } state_e;

    localparam int unsigned PRBS15_WIDTH  = 15;
    localparam logic [14:0] PRBS15_SEED   = '1;
    localparam int unsigned PRBS15_TAP_HI = 14;
    localparam int unsigned PRBS15_TAP_LO = 13;

endpackage

// File: rtl/prbs15_lfsr.sv
// PRBS15 (x^15+x^14+1) Fibonacci LFSR; load reseeds and takes priority over advance.
module prbs15_lfsr
    import sample_generator_pkg::*;
(
    input  logic        clock,
    input  logic        nReset,
    input  logic        load,
    input  logic        advance,
    output logic [14:0] state
);

    logic [14:0] state_q;
    logic [14:0] state_d;

    always_comb begin
        state_d = state_q;
        if (load) begin
            state_d = PRBS15_SEED;
        end else if (advance) begin
            state_d = {state_q[13:0], state_q[PRBS15_TAP_HI] ^ state_q[PRBS15_TAP_LO]};
        end
    end

    always_ff @(posedge clock or negedge nReset) begin
        if (!nReset) begin
            state_q <= PRBS15_SEED;
        end else begin
            state_q <= state_d;
        end
    end

    assign state = state_q;

endmodule

// File: rtl/sample_generator.sv
// Capture-path sample source: live ADC, ramp, PRBS15 or constant, with run handshake
// and saturating ADC clip counters.
module sample_generator
    import sample_generator_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 10,
    parameter int unsigned RAMP_MAX   = (1 << DATA_WIDTH) - 1,
    parameter int unsigned CLIP_WIDTH = 16
) (
    input  logic                  clock,
    input  logic                  nReset,
    input  logic [DATA_WIDTH-1:0] adc_databus,
    input  logic                  enable,
    input  logic [1:0]            mode,
    input  logic [DATA_WIDTH-1:0] constValue,
    input  logic                  clearCounters,
    output logic [DATA_WIDTH-1:0] dataOut,
    output logic                  dataValid,
    output logic [CLIP_WIDTH-1:0] clipLowCount,
    output logic [CLIP_WIDTH-1:0] clipHighCount
);

    if (DATA_WIDTH < 1 || DATA_WIDTH > 15) begin : g_bad_data_width
        $error("sample_generator: DATA_WIDTH must be 1..15");
    end
    if (RAMP_MAX > (1 << DATA_WIDTH) - 1) begin : g_bad_ramp_max
        $error("sample_generator: RAMP_MAX exceeds 2**DATA_WIDTH-1");
    end
    if (CLIP_WIDTH < 1) begin : g_bad_clip_width
        $error("sample_generator: CLIP_WIDTH must be at least 1");
    end

    localparam logic [DATA_WIDTH-1:0] RAMP_LAST = DATA_WIDTH'(RAMP_MAX);

    state_e                state_q, state_d;
    mode_e                 mode_q, mode_d;
    logic [DATA_WIDTH-1:0] adc_q;
    logic [DATA_WIDTH-1:0] ramp_q, ramp_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic                  valid_q, valid_d;
    logic [CLIP_WIDTH-1:0] clip_lo_q, clip_lo_d;
    logic [CLIP_WIDTH-1:0] clip_hi_q, clip_hi_d;
    logic                  word_en;
    logic                  lfsr_load;
    logic                  lfsr_advance;
    logic [14:0]           lfsr_state;

    prbs15_lfsr u_prbs15_lfsr (
        .clock   (clock),
        .nReset  (nReset),
        .load    (lfsr_load),
        .advance (lfsr_advance),
        .state   (lfsr_state)
    );

    // A word is produced on every edge that leaves the FSM in RUN, including PRIME->RUN.
    always_comb begin
        state_d      = state_q;
        mode_d       = mode_q;
        ramp_d       = ramp_q;
        data_d       = data_q;
        valid_d      = 1'b0;
        word_en      = 1'b0;
        lfsr_load    = 1'b0;
        lfsr_advance = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (enable) begin
                    state_d   = ST_PRIME;
                    mode_d    = mode_e'(mode);
                    ramp_d    = '0;
                    lfsr_load = 1'b1;
                end
            end
            ST_PRIME: begin
                if (enable) begin
                    state_d = ST_RUN;
                    word_en = 1'b1;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (enable) begin
                    word_en = 1'b1;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (word_en) begin
            valid_d = 1'b1;
            case (mode_q)
                MODE_ADC:   data_d = adc_q;
                MODE_RAMP: begin
                    data_d = ramp_q;
                    ramp_d = (ramp_q == RAMP_LAST) ? '0 : ramp_q + 1'b1;
                end
                MODE_PRBS: begin
                    data_d       = lfsr_state[DATA_WIDTH-1:0];
                    lfsr_advance = 1'b1;
                end
                MODE_CONST: data_d = constValue;
                default:    data_d = data_q;
            endcase
        end
    end

    always_comb begin
        clip_lo_d = clip_lo_q;
        clip_hi_d = clip_hi_q;
        if (clearCounters) begin
            clip_lo_d = '0;
            clip_hi_d = '0;
        end else if (state_q != ST_IDLE) begin
            if (adc_q == '0 && clip_lo_q != '1) begin
                clip_lo_d = clip_lo_q + 1'b1;
            end
            if (adc_q == '1 && clip_hi_q != '1) begin
                clip_hi_d = clip_hi_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clock or negedge nReset) begin
        if (!nReset) begin
            state_q   <= ST_IDLE;
            mode_q    <= MODE_ADC;
            adc_q     <= '0;
            ramp_q    <= '0;
            data_q    <= '0;
            valid_q   <= 1'b0;
            clip_lo_q <= '0;
            clip_hi_q <= '0;
        end else begin
            state_q   <= state_d;
            mode_q    <= mode_d;
            adc_q     <= adc_databus;
            ramp_q    <= ramp_d;
            data_q    <= data_d;
            valid_q   <= valid_d;
            clip_lo_q <= clip_lo_d;
            clip_hi_q <= clip_hi_d;
        end
    end

    assign dataOut       = data_q;
    assign dataValid     = valid_q;
    assign clipLowCount  = clip_lo_q;
    assign clipHighCount = clip_hi_q;

endmodule

// File: tb/tb_sample_generator.sv
// Directed self-checking bench for sample_generator (DATA_WIDTH 10, RAMP_MAX 5, CLIP_WIDTH 4).
module tb_sample_generator;

    localparam int unsigned DW = 10;
    localparam int unsigned CW = 4;

    logic          clock;
    logic          nReset;
    logic [DW-1:0] adc_databus;
    logic          enable;
    logic [1:0]    mode;
    logic [DW-1:0] constValue;
    logic          clearCounters;
    logic [DW-1:0] dataOut;
    logic          dataValid;
    logic [CW-1:0] clipLowCount;
    logic [CW-1:0] clipHighCount;

    int unsigned total = 0;
    int unsigned bad   = 0;

    sample_generator #(
        .DATA_WIDTH (DW),
        .RAMP_MAX   (5),
        .CLIP_WIDTH (CW)
    ) dut (
        .clock         (clock),
        .nReset        (nReset),
        .adc_databus   (adc_databus),
        .enable        (enable),
        .mode          (mode),
        .constValue    (constValue),
        .clearCounters (clearCounters),
        .dataOut       (dataOut),
        .dataValid     (dataValid),
        .clipLowCount  (clipLowCount),
        .clipHighCount (clipHighCount)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    initial begin
        logic [14:0]   m;
        int unsigned   errs;
        logic [DW-1:0] exp_word;
        int            ramp_exp [9] = '{0, 1, 2, 3, 4, 5, 0, 1, 2};

        nReset        = 1'b0;
        adc_databus   = 10'h123;
        enable        = 1'b0;
        mode          = 2'd0;
        constValue    = '0;
        clearCounters = 1'b0;
        #12;
        chk("rst_data", 32'(dataOut), 0);
        chk("rst_valid", 32'(dataValid), 0);
        chk("rst_lo", 32'(clipLowCount), 0);
        chk("rst_hi", 32'(clipHighCount), 0);
        nReset = 1'b1;
        tick();

        // Ramp with wrap at RAMP_MAX=5
        mode = 2'd1; enable = 1'b1;
        tick();
        chk("ramp_prime_valid", 32'(dataValid), 0);
        for (int i = 0; i < 9; i++) begin
            tick();
            chk("ramp_word", 32'(dataOut), 32'(ramp_exp[i]));
            chk("ramp_valid", 32'(dataValid), 1);
        end
        enable = 1'b0;
        tick();
        chk("ramp_stop_valid", 32'(dataValid), 0);
        chk("ramp_stop_hold", 32'(dataOut), 2);

        // Single-edge enable pulse: no word, then fresh ramp run starts at 0
        enable = 1'b1;
        tick();
        enable = 1'b0;
        tick();
        chk("pulse_valid0", 32'(dataValid), 0);
        tick();
        chk("pulse_valid1", 32'(dataValid), 0);
        chk("pulse_hold", 32'(dataOut), 2);
        enable = 1'b1;
        tick();
        tick();
        chk("rerun_ramp0", 32'(dataOut), 0);
        enable = 1'b0;
        tick();

        // ADC path: two-register latency, mid-run mode change ignored
        mode = 2'd0; enable = 1'b1; adc_databus = 10'd16;
        tick();
        for (int i = 1; i <= 8; i++) begin
            adc_databus = 10'(16 + i);
            if (i == 4) mode = 2'd2;
            tick();
            chk("adc_word", 32'(dataOut), 32'(16 + i - 1));
        end
        enable = 1'b0;
        tick();
        chk("adc_stop_valid", 32'(dataValid), 0);
        chk("adc_stop_hold", 32'(dataOut), 23);
        tick();

        // PRBS15: full period against an independent shift model
        mode = 2'd2; enable = 1'b1;
        tick();
        m    = 15'h7FFF;
        errs = 0;
        for (int n = 0; n < 32768; n++) begin
            tick();
            exp_word = m[DW-1:0];
            if (n < 4) begin
                chk("prbs_word", 32'(dataOut), 32'(exp_word));
            end else if (dataOut !== exp_word || dataValid !== 1'b1) begin
                errs++;
            end
            if (n == 32767) chk("prbs_period_wrap", 32'(dataOut), 32'h3FF);
            m = {m[13:0], m[14] ^ m[13]};
        end
        chk("prbs_stream_errs", errs, 0);
        enable = 1'b0;
        tick();
        chk("prbs_stop_valid", 32'(dataValid), 0);
        enable = 1'b1;
        tick();
        tick();
        chk("prbs_restart0", 32'(dataOut), 32'h3FF);
        tick();
        chk("prbs_restart1", 32'(dataOut), 32'h3FE);
        tick();
        chk("prbs_restart2", 32'(dataOut), 32'h3FC);
        enable = 1'b0;
        tick();

        // Constant: sampled each RUN edge, one-edge delay
        mode = 2'd3; constValue = 10'h155; enable = 1'b1;
        tick();
        tick();
        chk("const_a0", 32'(dataOut), 32'h155);
        tick();
        chk("const_a1", 32'(dataOut), 32'h155);
        constValue = 10'h2AA;
        tick();
        chk("const_b0", 32'(dataOut), 32'h2AA);
        chk("const_valid", 32'(dataValid), 1);
        enable = 1'b0;
        tick();

        // Clip counters
        adc_databus = '0; clearCounters = 1'b1;
        tick();
        clearCounters = 1'b0;
        chk("clip_clear_idle", 32'(clipLowCount), 0);
        tick();
        chk("clip_idle_hold", 32'(clipLowCount), 0);
        enable = 1'b1;
        tick();
        for (int i = 0; i < 5; i++) tick();
        chk("clip_lo_5", 32'(clipLowCount), 5);
        for (int i = 0; i < 15; i++) tick();
        chk("clip_lo_sat", 32'(clipLowCount), 15);
        chk("clip_hi_zero", 32'(clipHighCount), 0);
        clearCounters = 1'b1;
        tick();
        clearCounters = 1'b0;
        chk("clip_clear_wins", 32'(clipLowCount), 0);
        adc_databus = 10'h3FF;
        tick();
        tick();
        chk("clip_hi_1", 32'(clipHighCount), 1);
        chk("clip_lo_1", 32'(clipLowCount), 1);
        tick();
        chk("clip_hi_2", 32'(clipHighCount), 2);
        enable = 1'b0;
        tick();
        tick();
        chk("clip_hi_idle_hold", 32'(clipHighCount), 3);
        chk("clip_lo_idle_hold", 32'(clipLowCount), 1);

        // Asynchronous reset mid-run in ramp mode
        mode = 2'd1; enable = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        chk("pre_rst_data", 32'(dataOut), 3);
        #2;
        nReset = 1'b0;
        #1;
        chk("arst_data", 32'(dataOut), 0);
        chk("arst_valid", 32'(dataValid), 0);
        chk("arst_hi", 32'(clipHighCount), 0);
        chk("arst_lo", 32'(clipLowCount), 0);
        nReset = 1'b1;
        tick();
        chk("arst_prime_valid", 32'(dataValid), 0);
        tick();
        chk("arst_rerun0", 32'(dataOut), 0);
        chk("arst_rerun_valid", 32'(dataValid), 1);
        tick();
        chk("arst_rerun1", 32'(dataOut), 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/sample_generator.md
# sample_generator

Parametrised successor to the single-channel ADC/test-ramp source in the capture path. Registers the ADC bus and drives one sample stream to the FIFO/USB side, selecting per capture run between live ADC data, a configurable-length ramp, a PRBS15 sequence or a constant word. Adds a start/stop handshake (`enable` in, `dataValid` out) so every run starts deterministically, plus saturating ADC clip counters for level setting.

## Interface
- `DATA_WIDTH`, 10, sample width in bits; legal range 1..15.
- `RAMP_MAX`, 2**DATA_WIDTH-1, last ramp value before wrap to 0; must be ≤ 2**DATA_WIDTH-1.
- `CLIP_WIDTH`, 16, width of each clip counter.
- `clock`  in  1  sample clock; all logic on posedge.
- `nReset`  in  1  asynchronous, active-low reset.
- `adc_databus`  in  DATA_WIDTH  raw ADC word.
- `enable`  in  1  level; high = stream running.
- `mode`  in  2  source select: 0 ADC, 1 ramp, 2 PRBS15, 3 constant.
- `constValue`  in  DATA_WIDTH  word emitted in mode 3.
- `clearCounters`  in  1  synchronous clear of both clip counters.
- `dataOut`  out  DATA_WIDTH  sample word.
- `dataValid`  out  1  high while `dataOut` carries a stream sample.
- `clipLowCount`  out  CLIP_WIDTH  count of ADC samples equal to 0.
- `clipHighCount`  out  CLIP_WIDTH  count of ADC samples equal to all-ones.

## Operation
- Reset values: state IDLE, `dataOut` 0, `dataValid` 0, both counters 0, internal ADC register 0, ramp 0, LFSR all-ones, latched mode 0.
- States: IDLE → PRIME when `enable`=1; PRIME → RUN when `enable`=1, else → IDLE; RUN → IDLE when `enable`=0.
- `mode` latched only on the IDLE→PRIME edge; changes while PRIME/RUN ignored until next run.
- On IDLE→PRIME: ramp reset to 0, LFSR reset to all-ones.
- ADC register loads `adc_databus` every edge regardless of state.
- In RUN, each edge: `dataOut` ← selected source; ramp and LFSR advance only in RUN and only while their mode is latched.
- Ramp: 0,1,…,RAMP_MAX,0,… (wrap at RAMP_MAX, not at 2**DATA_WIDTH-1).
- PRBS15: x^15+x^14+1 Fibonacci LFSR, one shift per sample, new bit = lfsr[14]^lfsr[13] into bit 0; `dataOut` = lfsr[DATA_WIDTH-1:0] before shift.
- Constant: `constValue` sampled every RUN edge (not latched).
- IDLE/PRIME: `dataOut` holds last value, `dataValid` 0.
- Clip counters: in PRIME or RUN, increment on ADC register value 0 (low) or all-ones (high), independent of mode; saturate at 2**CLIP_WIDTH-1; `clearCounters` wins over a simultaneous increment; counters hold in IDLE.

## Timing
- Start latency: `enable` sampled high at edge E0 → `dataValid` high after E1; first word visible after E1.
- ADC mode: `adc_databus` sampled at edge k appears on `dataOut` after edge k+1 (2-register path).
- Ramp/PRBS first word after E1 is 0 / lfsr[DATA_WIDTH-1:0] of seed (all-ones), continuous thereafter with no gaps while `enable` stays high.
- Stop: `enable` sampled low at edge Ek → `dataValid` low after Ek; no further word.
- `enable` high for one edge only (IDLE→PRIME→IDLE): no valid word, generators re-seeded.
- `nReset` mid-run: all state to reset values immediately; no valid word until a fresh E0/E1 sequence.

## Structure
- Shared package: mode encodings (`MODE_ADC`, `MODE_RAMP`, `MODE_PRBS`, `MODE_CONST`), state encodings, PRBS15 seed and tap positions.
- One sub-module: `prbs15_lfsr` (clock, nReset, load, advance, 15-bit state out).
- Counters and ramp are inline; parameter legality checked at elaboration.

## Test plan
- Reset, mode 1, RAMP_MAX 5, `enable` high 10 edges → after E1 `dataOut` 0,1,2,3,4,5,0,1,2 with `dataValid` 1; `enable` low → `dataValid` 0 next edge, `dataOut` holds 2.
- Mode 0, `adc_databus` = edge index → `dataOut` after edge k+1 equals value applied at edge k; switching `mode` mid-run leaves ADC output unchanged.
- Mode 2, DATA_WIDTH 10 → first words 0x3FF, 0x3FE, 0x3FC…; 32767-word period with no repeat; restart reproduces identical sequence.
- Mode 3, `constValue` 0x155 then 0x2AA mid-run → `dataOut` follows with one-edge delay; `dataValid` continuous.
- Clip: CLIP_WIDTH 4, ADC held at 0 for 20 run edges → `clipLowCount` saturates at 15; `clearCounters` with simultaneous 0 sample → 0; ADC 0x3FF → only `clipHighCount` increments.
- `nReset` asserted mid-run in mode 1 → `dataOut` 0, `dataValid` 0, counters 0 immediately; re-enable → ramp restarts at 0.
